// File: rtl/mem_ctrl_pkg.sv
// Shared types and encodings for the memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT1 = 3'd1,
    REQ2  = 3'd2,
    WAIT2 = 3'd3,
    DONE  = 3'd4
  } state_e;

  // sizeSrcM (funct3) encodings
  localparam logic [2:0] SZ_LB  = 3'b000;
  localparam logic [2:0] SZ_LH  = 3'b001;
  localparam logic [2:0] SZ_LW  = 3'b010;
  localparam logic [2:0] SZ_LBU = 3'b100;
  localparam logic [2:0] SZ_LHU = 3'b101;

  localparam logic [1:0] ACC_BYTE = 2'b00;
  localparam logic [1:0] ACC_HALF = 2'b01;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Byte lanes touched by an access of the given width, starting at lane 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] acc);
    case (acc)
      ACC_BYTE: lane_mask = 4'b0001;
      ACC_HALF: lane_mask = 4'b0011;
      default:  lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load path: shifts the (possibly two-word) response down to the
// addressed byte and applies sign or zero extension.
module load_align
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [7:0]  bytes [8];
  logic [31:0] shifted;
  logic        sign_ext;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bytes[k]     = lo_i[8*k +: 8];
      bytes[k + 4] = hi_i[8*k +: 8];
    end
    // hi_i supplies the lanes that spill past the first word on split loads
    for (int k = 0; k < 4; k++) begin
      shifted[8*k +: 8] = bytes[3'(k) + {1'b0, off_i}];
    end
  end

  assign sign_ext = ~size_i[2];

  always_comb begin
    case (size_i[1:0])
      ACC_BYTE: data_o = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      ACC_HALF: data_o = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:  data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller bridging the pipeline to a valid/ready bus.
// Define MEM_MISALIGN_SPLIT_EN to split misaligned accesses into two bus beats.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            sizeSrcM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  req_valid,
  output logic                  req_we,
  output logic [DATA_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  output logic [3:0]            req_be,
  input  logic                  req_ready,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MisalignM
);

  state_e      state_q, state_d;
  logic [31:0] rd_q, rd_d;
  logic        mis_q, mis_d;
  logic [31:0] buf_q, buf_d;

  logic        op_present, is_store, is_load, misaligned;
  logic [1:0]  off, acc;
  logic [7:0]  be_span;
  logic [31:0] word_addr, wdata_rep, wdata_first, wdata_second;
  logic [31:0] align_lo, align_hi, align_data;
  logic        valid_c;

  assign is_store   = MemWriteM;
  assign is_load    = ~MemWriteM & (ResultSrcM == RESULT_SRC_LOAD);
  assign op_present = is_store | is_load;
  assign off        = ALUResultM[1:0];
  assign acc        = sizeSrcM[1:0];
  assign word_addr  = {ALUResultM[31:2], 2'b00};

  // Lanes past bit 3 belong to the next word, which is exactly the misaligned case
  assign be_span    = {4'b0000, lane_mask(acc)} << off;
  assign misaligned = |be_span[7:4];

  always_comb begin
    case (acc)
      ACC_BYTE: wdata_rep = {4{WriteDataM[7:0]}};
      ACC_HALF: wdata_rep = {2{WriteDataM[15:0]}};
      default:  wdata_rep = WriteDataM;
    endcase
  end

`ifdef MEM_MISALIGN_SPLIT_EN
  logic [63:0] wdata_shift;
  assign wdata_shift  = {32'h0, WriteDataM} << {off, 3'b000};
  assign wdata_first  = misaligned ? wdata_shift[31:0] : wdata_rep;
  assign wdata_second = wdata_shift[63:32];
`else
  assign wdata_first  = wdata_rep;
  assign wdata_second = wdata_rep;
`endif

  // On the second beat the first word sits in buf_q and the live response is the upper word
  assign align_lo = (state_q == WAIT2) ? buf_q : rsp_rdata;
  assign align_hi = (state_q == WAIT2) ? rsp_rdata : 32'h0;

  load_align u_load_align (
    .lo_i   (align_lo),
    .hi_i   (align_hi),
    .off_i  (off),
    .size_i (sizeSrcM),
    .data_o (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= 32'h0;
      mis_q   <= 1'b0;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    mis_d     = 1'b0;
    buf_d     = buf_q;
    valid_c   = 1'b0;
    req_addr  = word_addr;
    req_be    = be_span[3:0];
    req_wdata = wdata_first;
    case (state_q)
      IDLE: begin
        if (op_present) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          valid_c = 1'b1;
          if (req_ready) state_d = WAIT1;
`else
          if (misaligned) begin
            state_d = DONE;
            mis_d   = 1'b1;
            rd_d    = 32'h0;
          end else begin
            valid_c = 1'b1;
            if (req_ready) state_d = WAIT1;
          end
`endif
        end
      end
      WAIT1: begin
        if (rsp_valid) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          if (misaligned) begin
            buf_d   = rsp_rdata;
            state_d = REQ2;
          end else
`endif
          begin
            state_d = DONE;
            if (is_load) rd_d = align_data;
          end
        end
      end
      REQ2: begin
        valid_c   = 1'b1;
        req_addr  = word_addr + 32'd4;
        req_be    = be_span[7:4];
        req_wdata = wdata_second;
        if (req_ready) state_d = WAIT2;
      end
      WAIT2: begin
        if (rsp_valid) begin
          state_d = DONE;
          if (is_load) rd_d = align_data;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst_n keeps the bus quiet while reset is held even if an op is presented
  assign req_valid = valid_c & rst_n;
  assign req_we    = is_store;
  assign StallM    = op_present & (state_q != DONE);
  assign ReadDataM = rd_q;
  assign MisalignM = mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected bus beats and results are queued
// when an op is driven and compared as the bus accepts beats and the op completes.
module tb_mem_access_ctrl;

`ifdef MEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  sizeSrcM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        StallM, MisalignM;
  logic [31:0] ReadDataM;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .sizeSrcM   (sizeSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .MisalignM  (MisalignM)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        full;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          stall;
  } res_t;

  req_t        exp_req_q[$];
  res_t        exp_res_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_rd = 32'h0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return 32'h0;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] ba);
    logic [31:0] w;
    w = rd_word(ba & ~32'd3);
    return w[8*ba[1:0] +: 8];
  endfunction

  task automatic mem_write_byte(input logic [31:0] ba, input logic [7:0] b);
    logic [31:0] w;
    w = rd_word(ba & ~32'd3);
    w[8*ba[1:0] +: 8] = b;
    mem[ba & ~32'd3] = w;
  endtask

  task automatic drive_idle();
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b00;
    sizeSrcM   = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = 32'h0;
  endtask

  // Queue the expectations of one op, then drive it until it completes.
  task automatic run_op(input logic st, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int rdly, input int ddly);
    int          n, it, wait_cnt, due;
    int          stall;
    bit          mis, issue, done;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1, rep, ld, wa0, ba, rdata_pend, exp_rd;
    req_t        e;
    res_t        r;

    n     = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    mis   = (int'(a[1:0]) + n) > 4;
    issue = !mis || SPLIT;
    wa0   = a & ~32'd3;
    be0 = 4'h0; be1 = 4'h0; wd0 = 32'h0; wd1 = 32'h0; ld = 32'h0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      ld[8*i +: 8] = mem_byte(ba);
      if ((ba & ~32'd3) == wa0) begin
        be0[ba[1:0]] = 1'b1;
        wd0[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end else begin
        be1[ba[1:0]] = 1'b1;
        wd1[8*ba[1:0] +: 8] = wd[8*i +: 8];
      end
    end
    rep = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    if (!sz[2] && n == 1) ld = {{24{ld[7]}}, ld[7:0]};
    if (!sz[2] && n == 2) ld = {{16{ld[15]}}, ld[15:0]};

    if (!mis) begin
      exp_req_q.push_back('{addr: wa0, we: st, be: be0, wdata: rep, full: 1'b1});
    end else if (SPLIT) begin
      exp_req_q.push_back('{addr: wa0, we: st, be: be0, wdata: wd0, full: 1'b0});
      exp_req_q.push_back('{addr: wa0 + 32'd4, we: st, be: be1, wdata: wd1, full: 1'b0});
    end
    if (st && issue)
      for (int i = 0; i < n; i++) mem_write_byte(a + 32'(i), wd[8*i +: 8]);

    exp_rd  = !issue ? 32'h0 : (st ? last_rd : ld);
    last_rd = exp_rd;
    exp_res_q.push_back('{rd: exp_rd, mis: !issue,
                          stall: !issue ? 1 : (mis ? 2 : 1) * (rdly + ddly + 2)});

    @(negedge clk);
    MemWriteM  = st;
    ResultSrcM = st ? 2'b00 : 2'b01;
    sizeSrcM   = sz;
    ALUResultM = a;
    WriteDataM = wd;
    it = 0; wait_cnt = 0; stall = 0; due = -1; done = 0; rdata_pend = 32'h0;
    while (!done && it < 200) begin
      if (it > 0) @(negedge clk);
      rsp_valid = (it == due);
      rsp_rdata = (it == due) ? rdata_pend : 32'hBAD0BAD0;
      req_ready = (wait_cnt >= rdly);
      #1;
      if (StallM) stall++;
      if (req_valid) begin
        if (exp_req_q.size() == 0) begin
          chk("unexpected_req", 32'(req_valid), 32'h0);
        end else begin
          e = exp_req_q[0];
          chk("req_addr", req_addr, e.addr);
          chk("req_be", 32'(req_be), 32'(e.be));
          chk("req_we", 32'(req_we), 32'(e.we));
          if (req_ready) begin
            if (e.we)
              chk("req_wdata", e.full ? req_wdata : (req_wdata & {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}}), e.wdata);
            void'(exp_req_q.pop_front());
            due        = it + 1 + ddly;
            rdata_pend = rd_word(e.addr);
            wait_cnt   = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
      if (!StallM) begin
        r = exp_res_q.pop_front();
        chk("ReadDataM", ReadDataM, r.rd);
        chk("MisalignM", 32'(MisalignM), 32'(r.mis));
        chk("stall_cycles", 32'(stall), 32'(r.stall));
        done = 1;
      end
      it++;
    end
    if (!done) begin
      chk("timeout", 32'h0, 32'h1);
      exp_res_q.delete();
    end
    chk("reqs_left", 32'(exp_req_q.size()), 32'h0);
    exp_req_q.delete();
    $display("op st=%0d sz=%b addr=%h wdata=%h -> rd=%h mis=%0d stall=%0d", st, sz, a, wd,
             ReadDataM, MisalignM, stall);
    drive_idle();
    @(posedge clk);
  endtask

  initial begin
    logic [2:0]  ld_sizes [5];
    logic [2:0]  sz;
    logic        st;
    ld_sizes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    drive_idle();
    rst_n = 1'b0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h300] = 32'h44332211;
    mem[32'h304] = 32'h88776655;
    mem[32'h500] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_stall", 32'(StallM), 32'h0);
    chk("rst_rd", ReadDataM, 32'h0);
    chk("rst_mis", 32'(MisalignM), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0);          // LW -> DEADBEEF
    run_op(1'b1, 3'b010, 32'h100, 32'h80FFFFFF, 0, 0);   // SW
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 0, 0);          // LB -> FFFFFF80
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 0, 0);          // LBU -> 00000080
    run_op(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0);   // SH be=1100
    run_op(1'b0, 3'b001, 32'h202, 32'h0, 0, 1);          // LH -> FFFFABCD
    run_op(1'b0, 3'b101, 32'h202, 32'h0, 1, 0);          // LHU -> 0000ABCD
    run_op(1'b0, 3'b010, 32'h200, 32'h0, 5, 2);          // ready low 5 cycles
    run_op(1'b1, 3'b000, 32'h301, 32'h0000005A, 0, 0);   // SB
    run_op(1'b0, 3'b010, 32'h301, 32'h0, 0, 0);          // misaligned LW
    run_op(1'b0, 3'b001, 32'h303, 32'h0, 1, 1);          // misaligned LH
    run_op(1'b1, 3'b010, 32'h306, 32'hA1B2C3D4, 0, 0);   // misaligned SW
    run_op(1'b0, 3'b010, 32'h304, 32'h0, 0, 0);
    run_op(1'b0, 3'b101, 32'h301, 32'h0, 0, 0);          // half at lane 1 is aligned

    for (int i = 0; i < 12; i++) begin
      st = 1'($urandom_range(0, 1));
      sz = st ? 3'($urandom_range(0, 2)) : ld_sizes[$urandom_range(0, 4)];
      run_op(st, sz, 32'h600 + 32'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset during WAIT1, then a stale response must be dropped
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 0, 0);
    @(negedge clk);
    MemWriteM = 1'b0; ResultSrcM = 2'b01; sizeSrcM = 3'b010; ALUResultM = 32'h500;
    req_ready = 1'b1;
    #1;
    chk("rr_req_valid", 32'(req_valid), 32'h1);
    @(negedge clk);
    req_ready = 1'b0;
    #1;
    chk("rr_wait1_valid", 32'(req_valid), 32'h0);
    chk("rr_wait1_stall", 32'(StallM), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rr_rst_valid", 32'(req_valid), 32'h0);
    chk("rr_rst_rd", ReadDataM, 32'h0);
    chk("rr_rst_mis", 32'(MisalignM), 32'h0);
    @(negedge clk);
    ResultSrcM = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    rsp_valid = 1'b0;
    #1;
    chk("rr_stale_rd", ReadDataM, 32'h0);
    chk("rr_stale_stall", 32'(StallM), 32'h0);
    @(negedge clk);
    ResultSrcM = 2'b01;
    #1;
    chk("rr_idle_valid", 32'(req_valid), 32'h1);
    chk("rr_idle_stall", 32'(StallM), 32'h1);
    drive_idle();
    last_rd = 32'h0;
    @(posedge clk);
    run_op(1'b0, 3'b010, 32'h500, 32'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width (only 32 supported).
REQ-002 SHALL have ports: clk in 1, clock; rst_n in 1, reset, asynchronous, active-low.
REQ-003 SHALL have inputs MemWriteM 1 (store), ResultSrcM 2 (2'b01 = load), sizeSrcM 3 (funct3: 000 LB, 001 LH, 010 LW/SW, 100 LBU, 101 LHU; SB=000, SH=001), ALUResultM 32 (byte address), WriteDataM 32 (store data).
REQ-004 SHALL have bus outputs req_valid 1, req_we 1, req_addr 32 (word-aligned), req_wdata 32, req_be 4; bus inputs req_ready 1, rsp_valid 1 (read data or write ack), rsp_rdata 32.
REQ-005 SHALL have outputs StallM 1 (freeze PC/IF/ID/EX/MEM pipeline registers), ReadDataM 32 (extended load result), MisalignM 1 (fault flag).

Function
REQ-006 SHALL treat an op as present when MemWriteM=1 or ResultSrcM=2'b01; store takes priority if both are set.
REQ-007 SHALL run FSM IDLE, WAIT1, REQ2, WAIT2, DONE; REQ2/WAIT2 reachable only per REQ-017.
REQ-008 SHALL drive StallM = op present AND state != DONE, combinationally.
REQ-009 IDLE with op present: req_valid=1; on req_ready go to WAIT1, else hold IDLE with request stable.
REQ-010 WAIT1: req_valid=0; on rsp_valid go to DONE (or REQ2 when split); wait indefinitely otherwise.
REQ-011 DONE: one cycle, StallM=0, ReadDataM/MisalignM valid; next state IDLE unconditionally.
REQ-012 Minimum latency with req_ready=1 and rsp_valid one cycle after acceptance: op occupies MEM for 3 cycles (IDLE, WAIT1, DONE).
REQ-013 SHALL set req_addr = {ALUResultM[31:2],2'b00}; req_be = 0001<<a[1:0] (byte), 0011<<a[1:0] (half), 1111 (word).
REQ-014 SHALL replicate store data: byte x4, half x2, word as-is.
REQ-015 Load: register rsp_rdata >> 8*a[1:0], then sign-extend (000/001) or zero-extend (100/101) into ReadDataM at WAIT1->DONE (or WAIT2->DONE); stores leave ReadDataM unchanged.
REQ-016 SHALL ignore rsp_valid outside WAIT1/WAIT2.
REQ-017 Misaligned: half with a[1:0]=11, or word with a[1:0]!=00; handled per Configuration.

Reset
REQ-018 rst_n low SHALL asynchronously force state IDLE, req_valid=0, ReadDataM=0, MisalignM=0, split buffer=0.
REQ-019 Reset mid-transaction SHALL abandon the access; a response arriving after reset is dropped per REQ-016.

Configuration
REQ-020 With MEM_MISALIGN_SPLIT_EN defined: misaligned op SHALL issue a first access at the aligned word with upper byte lanes, then REQ2 issues the access at word+4 with the remaining lower lanes; WAIT2 merges both responses; MisalignM stays 0.
REQ-021 Without MEM_MISALIGN_SPLIT_EN: misaligned op SHALL issue no bus request; IDLE goes directly to DONE with MisalignM=1 and ReadDataM=0 for that cycle.

Structure
REQ-022 Package mem_ctrl_pkg SHALL hold the FSM state enum, sizeSrc encodings, and the load ResultSrc code.
REQ-023 SHALL instantiate combinational sub-module load_align (shift/merge plus extension); FSM and registers stay in mem_access_ctrl.

Verification
REQ-024 LW at 0x100, req_ready=1, rsp_rdata=0xDEADBEEF the next cycle -> StallM high 2 cycles, DONE with ReadDataM=0xDEADBEEF.
REQ-025 LB at 0x103 with rdata 0x80FFFFFF -> req_be=1000, ReadDataM=0xFFFFFF80; LBU -> 0x00000080.
REQ-026 SH at 0x202, WriteDataM=0x1234ABCD -> req_we=1, req_be=1100, req_wdata=0xABCDABCD; ack -> DONE.
REQ-027 req_ready held low 5 cycles -> req_valid/addr/be stable, StallM high throughout, no state change.
REQ-028 LW at 0x301: split build -> accesses 0x300 be=1110 and 0x304 be=0001, merged result; non-split build -> no request, MisalignM=1 one cycle.
REQ-029 rst_n low during WAIT1, then stale rsp_valid -> IDLE, outputs zero, response ignored.
